// File: rtl/serial_sum_pkg.sv
// Shared types and constants for the serial-sum arbiter.
package serial_sum_pkg;

    // Controller states; exactly one is active at a time.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Requester indices as carried on the grant output.
    localparam logic GRANT_0 = 1'b0;
    localparam logic GRANT_1 = 1'b1;

endpackage

// File: rtl/serial_acc.sv
// Accumulator datapath: loads a+b (one bit wider, no truncation) and shifts it
// out LSB first with zero fill.
module serial_acc #(
    parameter int reglength = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 shift,
    input  logic [reglength-1:0] a,
    input  logic [reglength-1:0] b,
    output logic                 sum_bit
);

    logic [reglength:0] acc;

    // Load the zero-extended sum, or shift right one place per cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
        end else if (load) begin
            acc <= {1'b0, a} + {1'b0, b};
        end else if (shift) begin
            acc <= {1'b0, acc[reglength:1]};
        end
    end

    assign sum_bit = acc[0];

endmodule

// File: rtl/serial_sum_arbiter.sv
// Two-requester round-robin arbiter in front of a bit-serial adder.
// Optional feature: define SERIAL_SUM_PARITY_EN to add the result_parity output.
module serial_sum_arbiter
    import serial_sum_pkg::*;
#(
    parameter int reglength = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0,
    input  logic                 req1,
    input  logic [reglength-1:0] a0,
    input  logic [reglength-1:0] b0,
    input  logic [reglength-1:0] a1,
    input  logic [reglength-1:0] b1,
    output logic                 ack0,
    output logic                 ack1,
    output logic                 grant,
    output logic                 busy,
    output logic                 sum_bit,
    output logic                 sum_valid,
    output logic [reglength:0]   result,
    output logic                 result_valid
`ifdef SERIAL_SUM_PARITY_EN
    ,
    output logic                 result_parity
`endif
);

    localparam int CW = (reglength < 1) ? 1 : $clog2(reglength + 1);
    localparam logic [CW-1:0] LAST = CW'(reglength);

    state_t                 state;
    logic [CW-1:0]          count;
    logic                   rr_ptr;
    logic                   winner;
    logic                   acc_bit;
    logic [reglength-1:0]   op_a;
    logic [reglength-1:0]   op_b;

    // Round-robin pick: a lone request wins, a tie goes to the pointer.
    always_comb begin
        winner = GRANT_0;
        if (req0 && req1) begin
            winner = rr_ptr;
        end else if (req1) begin
            winner = GRANT_1;
        end
    end

    // Operands of the granted requester feed the accumulator.
    always_comb begin
        op_a = a0;
        op_b = b0;
        if (grant == GRANT_1) begin
            op_a = a1;
            op_b = b1;
        end
    end

    serial_acc #(
        .reglength(reglength)
    ) u_acc (
        .clk    (clk),
        .reset  (reset),
        .load   (state == LOAD),
        .shift  (state == SHIFT),
        .a      (op_a),
        .b      (op_b),
        .sum_bit(acc_bit)
    );

    // Controller: state, grant, pointer, counter, result and registered flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            grant        <= GRANT_0;
            rr_ptr       <= GRANT_0;
            count        <= '0;
            result       <= '0;
            busy         <= 1'b0;
            sum_valid    <= 1'b0;
            result_valid <= 1'b0;
            ack0         <= 1'b0;
            ack1         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        grant <= winner;
                        busy  <= 1'b1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    count     <= '0;
                    result    <= '0;
                    sum_valid <= 1'b1;
                    state     <= SHIFT;
                end
                SHIFT: begin
                    result[count] <= acc_bit;
                    count         <= count + 1'b1;
                    if (count == LAST) begin
                        sum_valid    <= 1'b0;
                        result_valid <= 1'b1;
                        ack0         <= (grant == GRANT_0);
                        ack1         <= (grant == GRANT_1);
                        state        <= DONE;
                    end
                end
                DONE: begin
                    result_valid <= 1'b0;
                    ack0         <= 1'b0;
                    ack1         <= 1'b0;
                    busy         <= 1'b0;
                    rr_ptr       <= (grant == GRANT_0) ? GRANT_1 : GRANT_0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign sum_bit = sum_valid & acc_bit;

`ifdef SERIAL_SUM_PARITY_EN
    assign result_parity = result_valid & (^result);
`endif

endmodule

// File: tb/tb_serial_sum_arbiter.sv
// Directed self-checking bench for serial_sum_arbiter (reglength = 3).
module tb_serial_sum_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1;
    logic [2:0] a0, b0, a1, b1;
    logic       ack0, ack1, grant, busy, sum_bit, sum_valid, result_valid;
    logic [3:0] result;
`ifdef SERIAL_SUM_PARITY_EN
    logic       result_parity;
`endif

    int n_checks = 0;
    int n_errors = 0;

    serial_sum_arbiter #(
        .reglength(3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req0        (req0),
        .req1        (req1),
        .a0          (a0),
        .b0          (b0),
        .a1          (a1),
        .b1          (b1),
        .ack0        (ack0),
        .ack1        (ack1),
        .grant       (grant),
        .busy        (busy),
        .sum_bit     (sum_bit),
        .sum_valid   (sum_valid),
        .result      (result),
        .result_valid(result_valid)
`ifdef SERIAL_SUM_PARITY_EN
        ,
        .result_parity(result_parity)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Idle-state expectations, sampled at a falling edge.
    task automatic check_idle(input string tag);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".ack0"}, ack0, 0);
        check({tag, ".ack1"}, ack1, 0);
        check({tag, ".sum_valid"}, sum_valid, 0);
        check({tag, ".sum_bit"}, sum_bit, 0);
        check({tag, ".result_valid"}, result_valid, 0);
`ifdef SERIAL_SUM_PARITY_EN
        check({tag, ".parity"}, result_parity, 0);
`endif
    endtask

    // Request already presented before the sampling edge; follows LOAD, four
    // SHIFT cycles and DONE, dropping the request at ack (or early in SHIFT).
    task automatic do_op(input string tag, input logic g, input logic [3:0] exp_sum,
                         input logic exp_par, input bit drop_early);
        @(negedge clk);
        check({tag, ".load_grant"}, grant, g);
        check({tag, ".load_busy"}, busy, 1);
        check({tag, ".load_sv"}, sum_valid, 0);
        check({tag, ".load_sbit"}, sum_bit, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check({tag, ".shift_sv"}, sum_valid, 1);
            check({tag, ".shift_bit"}, sum_bit, exp_sum[i]);
            check({tag, ".shift_ack"}, ack0 | ack1, 0);
            if (drop_early && i == 0) begin
                if (g) req1 = 1'b0;
                else   req0 = 1'b0;
            end
        end
        @(negedge clk);
        check({tag, ".ack0"}, ack0, (g == 1'b0));
        check({tag, ".ack1"}, ack1, (g == 1'b1));
        check({tag, ".rv"}, result_valid, 1);
        check({tag, ".result"}, result, exp_sum);
        check({tag, ".done_sv"}, sum_valid, 0);
        check({tag, ".done_busy"}, busy, 1);
`ifdef SERIAL_SUM_PARITY_EN
        check({tag, ".parity"}, result_parity, exp_par);
`else
        if (exp_par === 1'bx) check({tag, ".par_arg"}, 0, 1);
`endif
        if (g) req1 = 1'b0;
        else   req0 = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        do_reset();

        // Reset state
        check_idle("reset");
        check("reset.result", result, 4'b0000);
        check("reset.grant", grant, 0);

        // Single request: 5 + 6 = 11 -> bits 1,1,0,1
        a0 = 3'd5; b0 = 3'd6; req0 = 1'b1;
        do_op("single", 1'b0, 4'b1011, 1'b1, 1'b0);
        @(negedge clk);
        check_idle("single_after");
        check("single.hold", result, 4'b1011);

        // Overflow on requester 1: 7 + 7 = 14
        a1 = 3'd7; b1 = 3'd7; req1 = 1'b1;
        do_op("ovf", 1'b1, 4'b1110, 1'b1, 1'b0);
        @(negedge clk);
        check_idle("ovf_after");

        // Tie after reset: 0 first, then 1 after one idle cycle, then 0 again
        do_reset();
        a0 = 3'd1; b0 = 3'd2; a1 = 3'd4; b1 = 3'd4;
        req0 = 1'b1; req1 = 1'b1;
        do_op("tie0", 1'b0, 4'b0011, 1'b0, 1'b0);
        @(negedge clk);
        check("tie.gap_busy", busy, 0);
        do_op("tie1", 1'b1, 4'b1000, 1'b1, 1'b0);
        @(negedge clk);
        check_idle("tie_gap2");
        a0 = 3'd0; b0 = 3'd0;
        req0 = 1'b1; req1 = 1'b1;
        do_op("tie2_0", 1'b0, 4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        do_op("tie2_1", 1'b1, 4'b1000, 1'b1, 1'b0);
        @(negedge clk);

        // Reset mid-SHIFT at count = 2, request held through reset
        a0 = 3'd3; b0 = 3'd2; req0 = 1'b1;
        @(negedge clk);                 // LOAD
        check("mid.load", busy, 1);
        @(negedge clk);                 // SHIFT count 0
        @(negedge clk);                 // SHIFT count 1
        @(negedge clk);                 // SHIFT count 2
        check("mid.in_shift", sum_valid, 1);
        reset = 1'b1;
        @(negedge clk);
        check_idle("mid_reset");
        check("mid.result", result, 4'b0000);
        reset = 1'b0;
        do_op("post_reset", 1'b0, 4'b0101, 1'b0, 1'b0);
        @(negedge clk);

        // Request dropped during SHIFT still completes: 6 + 3 = 9
        a0 = 3'd6; b0 = 3'd3; req0 = 1'b1;
        do_op("drop", 1'b0, 4'b1001, 1'b0, 1'b1);
        @(negedge clk);
        check_idle("drop_after");
        @(negedge clk);
        check("drop.no_restart", busy, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/serial_sum_arbiter.md
SERIAL_SUM_ARBITER -- requirements
Module: serial_sum_arbiter

Interface
REQ-001 Parameter: reglength, default 3, operand width in bits; the sum is reglength+1 bits.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0, req1  input  1 each  request from requester 0 / 1; held high until the matching ack.
REQ-005 a0, b0, a1, b1  input  reglength each  operands of requester 0 / 1; stable while the matching req is high.
REQ-006 ack0, ack1  output  1 each  one-cycle completion pulse to requester 0 / 1.
REQ-007 grant  output  1  index of the requester currently being served; valid while busy.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 sum_bit  output  1  serial sum bit, LSB first; valid while sum_valid.
REQ-010 sum_valid  output  1  high in SHIFT only.
REQ-011 result  output  reglength+1  parallel sum; valid while result_valid.
REQ-012 result_valid  output  1  high in DONE only, coincident with the ack.

Function
REQ-013 FSM states: IDLE, LOAD, SHIFT, DONE; exactly one active.
REQ-014 IDLE: if any req is high at an edge, latch the grant and go to LOAD; otherwise stay in IDLE.
REQ-015 Arbitration is round-robin. A single request wins. If both requests are high, the requester not served last wins. After reset, requester 0 wins a tie.
REQ-016 LOAD (1 cycle): the accumulator loads the granted a+b, zero-extended to reglength+1 bits with no truncation. The bit counter clears. Next state is SHIFT.
REQ-017 SHIFT (reglength+1 cycles): sum_bit = acc[0]. At each edge, result[count] <= acc[0], the accumulator shifts right one place with zero fill, and count increments. After count = reglength, go to DONE.
REQ-018 DONE (1 cycle): pulse ack for the granted requester, assert result_valid, update the round-robin pointer, then return to IDLE.
REQ-019 Latency: ack is high in the cycle following the (reglength+2)th edge after req is sampled in IDLE. Throughput is one operation per reglength+4 cycles.
REQ-020 A req that drops after grant does not abort the operation. It completes and ack still pulses.
REQ-021 Requests arriving while busy are not sampled until IDLE. Operand changes during LOAD are ignored after the load edge.
REQ-022 result holds its value after DONE until the next LOAD edge. sum_bit is 0 outside SHIFT.

Reset
REQ-023 When reset is high at an edge: state becomes IDLE, the accumulator, counter, result and round-robin pointer (favouring requester 0) become 0, and all outputs become 0.
REQ-024 A reset in any state, including mid-SHIFT, abandons the operation with no ack. Reset dominates the requests in the same cycle.

Configuration
REQ-025 Macro SERIAL_SUM_PARITY_EN:
- When defined: the block adds an output result_parity (1 bit) = XOR of all captured sum bits, valid with result_valid and 0 otherwise.
- When undefined: the port and its logic are absent, and all other behaviour is unchanged.

Structure
REQ-026 Shared package serial_sum_pkg holds:
- the FSM state enum type;
- the grant index constants GRANT_0 and GRANT_1.
REQ-027 Sub-module serial_acc holds the accumulator datapath:
- inputs: clk, reset, load, shift, a, b;
- output: sum_bit.
REQ-028 serial_sum_arbiter holds the FSM, the arbiter, the counter and the result register.

Verification (reglength=3)
REQ-029 Single request: req0, a0=5, b0=6 → grant=0; sum_bit sequence 1,1,0,1; ack0 and result_valid after 5 edges; result=4'b1011.
REQ-030 Overflow: req1, a1=7, b1=7 → result=4'b1110; ack1 pulses and ack0 stays 0.
REQ-031 Tie after reset: req0 and req1 high together → requester 0 is served first, then requester 1 with no IDLE gap beyond one cycle. A second tie after that → requester 0 again (pointer alternates).
REQ-032 Reset mid-SHIFT (count=2) → next cycle is IDLE with busy=0, no ack, and result=0.
REQ-033 req0 dropped during SHIFT → the operation completes and ack0 pulses with the correct result.
REQ-034 With SERIAL_SUM_PARITY_EN and 5+6 → result_parity=1. With 7+7 → result_parity=1. With 0+0 → result_parity=0.
